// File: rtl/switch_toggle_ctrl_if.sv
// Switch/LED bundle between the board pins and the toggle controller.
interface switch_toggle_ctrl_if #(
  parameter int unsigned NUM_SW = 4
);
  logic [NUM_SW-1:0] i_Switch;
  logic              i_LED_Clear;
  logic [NUM_SW-1:0] o_LED;
  logic [NUM_SW-1:0] o_Switch_Stable;
  logic [NUM_SW-1:0] o_Release_Pulse;

  modport master (
    output i_Switch, i_LED_Clear,
    input  o_LED, o_Switch_Stable, o_Release_Pulse
  );

  modport slave (
    input  i_Switch, i_LED_Clear,
    output o_LED, o_Switch_Stable, o_Release_Pulse
  );
endinterface

// File: rtl/switch_toggle_ctrl.sv
// Debounced, clearable switch-to-LED toggle controller; one independent
// synchroniser + debounce FSM + LED toggle register per channel.
module switch_toggle_ctrl #(
  parameter int unsigned NUM_SW         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  switch_toggle_ctrl_if.slave  bus
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } state_t;

  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;

  state_t            state   [NUM_SW];
  state_t            state_d [NUM_SW];
  logic [CNT_W-1:0]  cnt     [NUM_SW];
  logic [CNT_W-1:0]  cnt_d   [NUM_SW];

  logic [NUM_SW-1:0] stable, stable_d;
  logic [NUM_SW-1:0] led, led_d;
  logic [NUM_SW-1:0] pulse, pulse_d;
  logic [NUM_SW-1:0] rel;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.i_Switch;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce next-state, counter and release/toggle decode.
  always_comb begin
    stable_d = stable;
    rel      = '0;
    for (int unsigned n = 0; n < NUM_SW; n++) begin
      state_d[n] = state[n];
      cnt_d[n]   = cnt[n];
      case (state[n])
        S_LOW: begin
          if (sync2[n]) begin
            state_d[n] = S_WAIT_HIGH;
            cnt_d[n]   = CNT_ONE;
          end
        end
        S_WAIT_HIGH: begin
          if (!sync2[n]) begin
            state_d[n] = S_LOW;
            cnt_d[n]   = '0;
          end else if (cnt[n] == CNT_LAST) begin
            state_d[n]  = S_HIGH;
            stable_d[n] = 1'b1;
            cnt_d[n]    = '0;
          end else if (cnt[n] != '1) begin
            cnt_d[n] = cnt[n] + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync2[n]) begin
            state_d[n] = S_WAIT_LOW;
            cnt_d[n]   = CNT_ONE;
          end
        end
        S_WAIT_LOW: begin
          if (sync2[n]) begin
            state_d[n] = S_HIGH;
            cnt_d[n]   = '0;
          end else if (cnt[n] == CNT_LAST) begin
            state_d[n]  = S_LOW;
            stable_d[n] = 1'b0;
            cnt_d[n]    = '0;
            rel[n]      = 1'b1;
          end else if (cnt[n] != '1) begin
            cnt_d[n] = cnt[n] + CNT_ONE;
          end
        end
        default: begin
          state_d[n] = S_LOW;
          cnt_d[n]   = '0;
        end
      endcase
    end
    // Clear overrides a same-edge toggle; the release pulse is still issued.
    pulse_d = rel;
    led_d   = bus.i_LED_Clear ? '0 : (led ^ rel);
  end

  // State, counter and registered output update.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int unsigned n = 0; n < NUM_SW; n++) begin
        state[n] <= S_LOW;
        cnt[n]   <= '0;
      end
      stable <= '0;
      led    <= '0;
      pulse  <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_SW; n++) begin
        state[n] <= state_d[n];
        cnt[n]   <= cnt_d[n];
      end
      stable <= stable_d;
      led    <= led_d;
      pulse  <= pulse_d;
    end
  end

  assign bus.o_LED           = led;
  assign bus.o_Switch_Stable = stable;
  assign bus.o_Release_Pulse = pulse;

endmodule

// File: tb/tb_switch_toggle_ctrl.sv
// Directed bench for switch_toggle_ctrl with DEBOUNCE_LIMIT=4, NUM_SW=4.
// Expected output words are queued with the cycle they are due on and
// checked 1 time unit after that rising edge.
module tb_switch_toggle_ctrl;

  typedef struct {
    int        due;
    string     tag;
    logic [3:0] led;
    logic [3:0] stable;
    logic [3:0] pulse;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  switch_toggle_ctrl_if #(.NUM_SW(4)) bus ();

  switch_toggle_ctrl #(
    .NUM_SW(4),
    .DEBOUNCE_LIMIT(4)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_at(input int due, input string tag,
                           input logic [3:0] led, input logic [3:0] stable,
                           input logic [3:0] pulse);
    exp_t e;
    e.due = due; e.tag = tag; e.led = led; e.stable = stable; e.pulse = pulse;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        e = sb[i];
        sb.delete(i);
        total++;
        assert (e.due == cyc &&
                {bus.o_LED, bus.o_Switch_Stable, bus.o_Release_Pulse} ===
                {e.led, e.stable, e.pulse})
        else begin
          bad++;
          $error("FAIL %s cyc=%0d due=%0d got led=%b stable=%b pulse=%b want led=%b stable=%b pulse=%b",
                 e.tag, cyc, e.due, bus.o_LED, bus.o_Switch_Stable,
                 bus.o_Release_Pulse, e.led, e.stable, e.pulse);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with all switches held pressed.
    rst = 1'b1;
    bus.i_Switch    = 4'b1111;
    bus.i_LED_Clear = 1'b0;
    expect_at(3, "rst_hold", 4'b0000, 4'b0000, 4'b0000);
    run_to(3);
    rst = 1'b0;
    expect_at(8, "rst_press_pre", 4'b0000, 4'b0000, 4'b0000);
    expect_at(9, "rst_press",     4'b0000, 4'b1111, 4'b0000);
    run_to(10);

    // All four released together: simultaneous toggles and pulses.
    bus.i_Switch = 4'b0000;
    expect_at(15, "all_rel_pre", 4'b0000, 4'b1111, 4'b0000);
    expect_at(16, "all_rel",     4'b1111, 4'b0000, 4'b1111);
    expect_at(17, "all_rel_end", 4'b1111, 4'b0000, 4'b0000);
    run_to(17);
    bus.i_LED_Clear = 1'b1;
    expect_at(18, "clear_all", 4'b0000, 4'b0000, 4'b0000);
    run_to(18);
    bus.i_LED_Clear = 1'b0;

    // Clean press/release on ch0, twice.
    bus.i_Switch = 4'b0001;
    expect_at(23, "ch0_press_pre", 4'b0000, 4'b0000, 4'b0000);
    expect_at(24, "ch0_press",     4'b0000, 4'b0001, 4'b0000);
    run_to(28);
    bus.i_Switch = 4'b0000;
    expect_at(33, "ch0_rel_pre", 4'b0000, 4'b0001, 4'b0000);
    expect_at(34, "ch0_rel",     4'b0001, 4'b0000, 4'b0001);
    expect_at(35, "ch0_rel_end", 4'b0001, 4'b0000, 4'b0000);
    run_to(35);
    bus.i_Switch = 4'b0001;
    expect_at(41, "ch0_press2", 4'b0001, 4'b0001, 4'b0000);
    run_to(43);
    bus.i_Switch = 4'b0000;
    expect_at(49, "ch0_rel2",     4'b0000, 4'b0000, 4'b0001);
    expect_at(50, "ch0_rel2_end", 4'b0000, 4'b0000, 4'b0000);
    run_to(50);

    // Bouncing press on ch1: high runs of 1,2,3 then steady high.
    bus.i_Switch = 4'b0010; run_to(51);
    bus.i_Switch = 4'b0000; run_to(52);
    bus.i_Switch = 4'b0010; run_to(54);
    bus.i_Switch = 4'b0000; run_to(55);
    bus.i_Switch = 4'b0010; run_to(58);
    bus.i_Switch = 4'b0000; run_to(59);
    bus.i_Switch = 4'b0010;
    expect_at(61, "bounce_rej", 4'b0000, 4'b0000, 4'b0000);
    expect_at(64, "bounce_pre", 4'b0000, 4'b0000, 4'b0000);
    expect_at(65, "bounce_acc", 4'b0000, 4'b0010, 4'b0000);
    run_to(66);

    // Bouncing release on ch1: 3 low, 1 high, then steady low.
    bus.i_Switch = 4'b0000; run_to(69);
    bus.i_Switch = 4'b0010; run_to(70);
    bus.i_Switch = 4'b0000;
    expect_at(72, "relb_rej", 4'b0000, 4'b0010, 4'b0000);
    expect_at(75, "relb_pre", 4'b0000, 4'b0010, 4'b0000);
    expect_at(76, "relb_acc", 4'b0010, 4'b0000, 4'b0010);
    expect_at(77, "relb_end", 4'b0010, 4'b0000, 4'b0000);
    run_to(77);

    // Clear on the same edge as ch0's accepted release.
    bus.i_Switch = 4'b0001;
    expect_at(83, "ch0_press3", 4'b0010, 4'b0001, 4'b0000);
    run_to(84);
    bus.i_Switch = 4'b0000;
    expect_at(89, "clr_col_pre", 4'b0010, 4'b0001, 4'b0000);
    run_to(89);
    bus.i_LED_Clear = 1'b1;
    expect_at(90, "clr_col", 4'b0000, 4'b0000, 4'b0001);
    run_to(90);
    bus.i_LED_Clear = 1'b0;
    expect_at(91, "clr_col_end", 4'b0000, 4'b0000, 4'b0000);
    run_to(91);

    // Build LED=1010, then clear while ch2 is held stable.
    bus.i_Switch = 4'b1010;
    expect_at(97, "ch13_press", 4'b0000, 4'b1010, 4'b0000);
    run_to(98);
    bus.i_Switch = 4'b0000;
    expect_at(104, "ch13_rel", 4'b1010, 4'b0000, 4'b1010);
    run_to(105);
    bus.i_Switch = 4'b0100;
    expect_at(111, "ch2_press", 4'b1010, 4'b0100, 4'b0000);
    run_to(112);
    bus.i_LED_Clear = 1'b1;
    expect_at(113, "clear_1010", 4'b0000, 4'b0100, 4'b0000);
    run_to(113);
    bus.i_LED_Clear = 1'b0;

    // Reset while ch2 sits in S_WAIT_LOW with count=2.
    bus.i_Switch = 4'b0000;
    expect_at(117, "mid_pre", 4'b0000, 4'b0100, 4'b0000);
    run_to(117);
    rst = 1'b1;
    expect_at(118, "mid_rst", 4'b0000, 4'b0000, 4'b0000);
    run_to(118);
    rst = 1'b0;
    expect_at(119, "mid_no_rel", 4'b0000, 4'b0000, 4'b0000);
    expect_at(125, "mid_quiet",  4'b0000, 4'b0000, 4'b0000);
    run_to(126);

    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s never checked due=%0d got none want led=%b stable=%b pulse=%b",
               sb[0].tag, sb[0].due, sb[0].led, sb[0].stable, sb[0].pulse);
      void'(sb.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_toggle_ctrl.md
Name: switch_toggle_ctrl

Overview:
- Multi-channel controller that sequences the switch-to-LED toggle path for the board's push-buttons.
- Per channel: 2-flop input synchroniser, debounce FSM with counter, release detection and LED toggle register.
- Sits between the top-level i_Switch_* pins and o_LED_* pins, replacing the raw one-register edge-detect toggle with a debounced, clearable version.

Parameters:
- NUM_SW, 4, number of independent switch/LED channels (1..8).
- DEBOUNCE_LIMIT, 250000, consecutive clocks a new level must hold before acceptance (10 ms at 25 MHz); legal range is 2 or greater.

Ports:
- i_Clk  input  1  system clock; all logic on the rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Switch  input  NUM_SW  raw asynchronous switch levels; 1 = pressed.
- i_LED_Clear  input  1  synchronous clear of all LED toggle registers.
- o_LED  output  NUM_SW  LED drive; 1 = on; registered.
- o_Switch_Stable  output  NUM_SW  debounced switch level; registered.
- o_Release_Pulse  output  NUM_SW  one-clock pulse on an accepted 1->0 transition; registered.

Behaviour:
- Clock and reset:
  - One clock, i_Clk.
  - i_Rst is synchronous and active-high.
  - While i_Rst is high at an edge, the following all go to 0: sync flops, counters, FSM state (S_LOW), o_LED, o_Switch_Stable, o_Release_Pulse.
- Synchroniser: i_Switch[n] -> sync1[n] -> sync2[n]; the FSM uses only sync2.
- Counter:
  - Per-channel counter, width $clog2(DEBOUNCE_LIMIT).
  - Saturates; never wraps.
- FSM states, per channel:
  - S_LOW (stable = 0). If sync2 = 1 -> S_WAIT_HIGH, count = 1.
  - S_WAIT_HIGH:
    - If sync2 = 0 -> S_LOW, count = 0 (bounce rejected).
    - Else if count = DEBOUNCE_LIMIT-1 -> S_HIGH, stable <= 1, count = 0.
    - Else count + 1.
  - S_HIGH (stable = 1). If sync2 = 0 -> S_WAIT_LOW, count = 1.
  - S_WAIT_LOW:
    - If sync2 = 1 -> S_HIGH, count = 0.
    - Else if count = DEBOUNCE_LIMIT-1 -> S_LOW, stable <= 0, count = 0, o_Release_Pulse[n] <= 1, LED toggles.
    - Else count + 1.
- Latency:
  - Let edge E be the first edge at which sync1 captures the new level.
  - o_Switch_Stable changes at edge E + DEBOUNCE_LIMIT + 1.
  - o_LED and o_Release_Pulse change on that same edge (release only).
- Release pulse: o_Release_Pulse[n] is high for exactly one clock and 0 otherwise.
- Press: the accepted 0->1 transition updates stable only; no toggle, no pulse.
- i_LED_Clear:
  - Forces o_LED <= 0 on the next edge.
  - Does not affect FSMs, counters, o_Switch_Stable or o_Release_Pulse.
  - Simultaneous with an accepted release on the same edge: the clear wins (LED = 0) and the pulse is still issued.
- Channels are fully independent; simultaneous releases on several channels all toggle on the same edge.
- Reset mid-debounce:
  - The count is discarded.
  - A switch held pressed through reset is re-debounced as a press after reset and causes no toggle until it is released.
- Glitch rejection: a level held fewer than DEBOUNCE_LIMIT consecutive sync2 cycles never changes o_Switch_Stable.

Test Plan:
- All scenarios use DEBOUNCE_LIMIT=4, NUM_SW=4.
- Reset: hold i_Switch=4'b1111 with i_Rst=1 for 3 clocks -> o_LED=0, o_Switch_Stable=0, o_Release_Pulse=0. Release reset -> o_Switch_Stable=4'b1111 at edge E+5, o_LED stays 0.
- Clean press/release ch0: i_Switch[0] 0->1, held 10 clocks, then 1->0 -> stable[0] rises at E+5. On release, stable[0] falls, o_LED[0]=1 and o_Release_Pulse[0]=1 for exactly one clock at E'+5. A second press/release -> o_LED[0]=0.
- Bounce rejection ch1: pulses of 1,1,0,1,1,1,0 clocks high/low, then steady high -> stable[1] rises only after 4 consecutive high sync2 cycles. Bounce on release (3 low, 1 high, then steady low) -> exactly one toggle and one pulse.
- Simultaneous releases: ch2 and ch3 released on the same clock after a stable press -> o_LED[3:2]=2'b11 and o_Release_Pulse[3:2]=2'b11 on the same edge.
- Clear collision: i_LED_Clear asserted on the exact edge of ch0's accepted release, with o_LED[0]=0 beforehand -> o_LED[0]=0 and o_Release_Pulse[0]=1. Clear asserted while o_LED=4'b1010 -> o_LED=0 next edge, o_Switch_Stable unchanged.
- Reset mid-operation: assert i_Rst for 1 clock when ch0 count=2 in S_WAIT_LOW -> state S_LOW, count 0, o_LED[0]=0, no pulse. With the switch still released, no further events occur.
